// File: rtl/fir_capture_buf.sv
// Triggered capture buffer for the LP/HP/BP/MA FIR outputs, with a one-sample-per-cycle readback port.
// Optional running min/max of the captured window: define FIR_CAP_MINMAX_EN.
module fir_capture_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] lp_in,
  input  logic signed [DATA_W-1:0] hp_in,
  input  logic signed [DATA_W-1:0] bp_in,
  input  logic signed [DATA_W-1:0] ma_in,
  input  logic                     in_valid,
  input  logic [1:0]               ch_sel,
  input  logic                     trig_mode,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic                     arm,
  output logic                     busy,
  output logic                     done,
  input  logic                     rd_en,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     rd_last
`ifdef FIR_CAP_MINMAX_EN
  ,
  output logic signed [DATA_W-1:0] cap_min,
  output logic signed [DATA_W-1:0] cap_max
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t                   state_q, state_d;
  logic [1:0]               ch_q, ch_d;
  logic                     mode_q, mode_d;
  logic signed [DATA_W-1:0] thr_q, thr_d;
  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic                     prev_vld_q, prev_vld_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic                     rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic signed [DATA_W-1:0] rd_data_q;
  logic signed [DATA_W-1:0] samp;
  logic                     arm_take, trig_hit, mem_we, rd_issue;
  logic [DATA_W-1:0]        mem [DEPTH];

  always_comb begin
    unique case (ch_q)
      2'd0:    samp = lp_in;
      2'd1:    samp = hp_in;
      2'd2:    samp = bp_in;
      default: samp = ma_in;
    endcase
  end

  // arm is honoured everywhere except mid-capture; in DONE it wins over rd_en.
  assign arm_take = arm && (state_q != S_CAPTURE);
  assign trig_hit = in_valid && (!mode_q || (prev_vld_q && (prev_q < thr_q) && (samp >= thr_q)));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    ch_d       = ch_q;
    mode_d     = mode_q;
    thr_d      = thr_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    mem_we     = 1'b0;
    rd_issue   = 1'b0;
    if (arm_take) begin
      ch_d       = ch_sel;
      mode_d     = trig_mode;
      thr_d      = threshold;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      prev_vld_d = 1'b0;
      state_d    = S_ARMED;
    end else begin
      unique case (state_q)
        S_ARMED: begin
          if (trig_hit) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            state_d  = S_CAPTURE;
          end else if (in_valid) begin
            prev_d     = samp;
            prev_vld_d = 1'b1;
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == LAST_ADDR) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (rd_en) begin
            rd_issue   = 1'b1;
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            if (rd_ptr_q == LAST_ADDR) begin
              rd_last_d = 1'b1;
              state_d   = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      mode_q     <= 1'b0;
      thr_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      mode_q     <= mode_d;
      thr_q      <= thr_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      if (rd_issue) rd_data_q <= mem[rd_ptr_q];
    end
  end

  // NOTE: the sample RAM has no reset; its contents are only observable after a full capture.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= samp;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;

`ifdef FIR_CAP_MINMAX_EN
  logic signed [DATA_W-1:0] cap_min_q, cap_min_d, cap_max_q, cap_max_d;

  // Only the ARMED->CAPTURE write lands on address 0, so it seeds both extremes.
  always_comb begin
    cap_min_d = cap_min_q;
    cap_max_d = cap_max_q;
    if (arm_take) begin
      cap_min_d = '0;
      cap_max_d = '0;
    end else if (mem_we && (wr_ptr_q == '0)) begin
      cap_min_d = samp;
      cap_max_d = samp;
    end else if (mem_we) begin
      if (samp < cap_min_q) cap_min_d = samp;
      if (samp > cap_max_q) cap_max_d = samp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_min_q <= '0;
      cap_max_q <= '0;
    end else begin
      cap_min_q <= cap_min_d;
      cap_max_q <= cap_max_d;
    end
  end

  assign cap_min = cap_min_q;
  assign cap_max = cap_max_q;
`endif

endmodule

// File: tb/tb_fir_capture_buf.sv
// Scoreboard bench for fir_capture_buf: directed captures on each channel, readback checked by a monitor.
module tb_fir_capture_buf;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic signed [DATA_W-1:0] lp_in, hp_in, bp_in, ma_in, threshold, rd_data;
  logic                     in_valid, trig_mode, arm, busy, done, rd_en, rd_valid, rd_last;
  logic [1:0]               ch_sel;
`ifdef FIR_CAP_MINMAX_EN
  logic signed [DATA_W-1:0] cap_min, cap_max;
`endif

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fir_capture_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lp_in    (lp_in),
    .hp_in    (hp_in),
    .bp_in    (bp_in),
    .ma_in    (ma_in),
    .in_valid (in_valid),
    .ch_sel   (ch_sel),
    .trig_mode(trig_mode),
    .threshold(threshold),
    .arm      (arm),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_last  (rd_last)
`ifdef FIR_CAP_MINMAX_EN
    ,
    .cap_min  (cap_min),
    .cap_max  (cap_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unselected channels carry distinct values so a wrong channel mux shows up in readback.
  task automatic drive(input int ch, input int v, input bit vld);
    lp_in    = (ch == 0) ? 16'(v) : 16'sd1111;
    hp_in    = (ch == 1) ? 16'(v) : -16'sd2222;
    bp_in    = (ch == 2) ? 16'(v) : 16'sd3333;
    ma_in    = (ch == 3) ? 16'(v) : -16'sd4444;
    in_valid = vld;
  endtask

  task automatic do_arm(input int ch, input bit mode, input int thr, input bit with_rd);
    ch_sel    = 2'(ch);
    trig_mode = mode;
    threshold = 16'(thr);
    arm       = 1'b1;
    rd_en     = with_rd;
    tick();
    arm       = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic capture(input string name, input int ch, input int pat[$], input bit gapped,
                         output int n_valid, output int n_cyc);
    int k;
    k       = 0;
    n_valid = 0;
    n_cyc   = 0;
    while (!done && n_cyc < 400) begin
      if (gapped && n_cyc[0]) drive(ch, 777, 1'b0);
      else begin
        drive(ch, pat[k % pat.size()], 1'b1);
        k++;
        n_valid++;
      end
      tick();
      n_cyc++;
    end
    drive(ch, 0, 1'b0);
    check({name, "_done"}, int'(done), 1);
    check({name, "_busy_at_done"}, int'(busy), 0);
  endtask

  task automatic read_back(input int pat[$], input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      sb.push_back('{pat[i % pat.size()], (i == DEPTH - 1)});
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    tick();
    tick();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (sb.size() == 0) check("rd_valid_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("rd_data", int'(rd_data), e.data);
          check("rd_last", int'(rd_last), int'(e.last));
        end
      end
    end
  end

  initial begin : stim
    int ramp[$];
    int alt[$];
    int quad[$];
    int nv, nc;
    for (int i = 1; i <= 40; i++) ramp.push_back(i);
    alt  = '{50, -50};
    quad = '{50, 0, -50, 0};

    rst_n = 1'b0; arm = 1'b0; rd_en = 1'b0; ch_sel = 2'd0; trig_mode = 1'b0; threshold = '0;
    drive(0, 0, 1'b0);
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_last", int'(rd_last), 0);
    check("rst_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a capture.
    do_arm(0, 1'b0, 0, 1'b0);
    check("arm_busy", int'(busy), 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 100 + i, 1'b1);
      tick();
    end
    check("midcap_busy", int'(busy), 1);
    rst_n = 1'b0;
    drive(0, 0, 1'b0);
    tick();
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_rd_valid", int'(rd_valid), 0);
    rst_n = 1'b1;
    tick();

    // Immediate trigger on LP with a ramp.
    do_arm(0, 1'b0, 0, 1'b0);
    capture("lp", 0, ramp, 1'b0, nv, nc);
    check("lp_samples", nv, 32);
`ifdef FIR_CAP_MINMAX_EN
    check("lp_min", int'(cap_min), 1);
    check("lp_max", int'(cap_max), 32);
`endif
    read_back(ramp, 0, DEPTH);
    check("lp_idle_busy", int'(busy), 0);
    check("lp_idle_done", int'(done), 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("rd_after_last", int'(rd_valid), 0);
    tick();

    // Rising crossing through 0 on HP; first sample must not trigger.
    do_arm(1, 1'b1, 0, 1'b0);
    capture("hp", 1, alt, 1'b0, nv, nc);
    check("hp_samples", nv, 34);
    read_back(alt, 0, DEPTH);

    // Gapped valid on MA, then a partial readback.
    do_arm(3, 1'b0, 0, 1'b0);
    capture("ma", 3, quad, 1'b1, nv, nc);
    check("ma_samples", nv, 32);
    check("ma_cycles", nc, 63);
`ifdef FIR_CAP_MINMAX_EN
    check("ma_min", int'(cap_min), -50);
    check("ma_max", int'(cap_max), 50);
`endif
    read_back(quad, 0, 16);
    check("ma_still_done", int'(done), 1);

    // arm and rd_en together in DONE: arm wins, re-arming on BP.
    do_arm(2, 1'b0, 0, 1'b1);
    check("collide_rd_valid", int'(rd_valid), 0);
    check("collide_busy", int'(busy), 1);
    check("collide_done", int'(done), 0);
`ifdef FIR_CAP_MINMAX_EN
    check("collide_min", int'(cap_min), 0);
    check("collide_max", int'(cap_max), 0);
`endif

    capture("bp", 2, quad, 1'b0, nv, nc);
    check("bp_samples", nv, 32);
`ifdef FIR_CAP_MINMAX_EN
    check("bp_min", int'(cap_min), -50);
    check("bp_max", int'(cap_max), 50);
`endif
    read_back(quad, 0, DEPTH);
    check("sb_drained", sb.size(), 0);

    do_arm(2, 1'b0, 0, 1'b0);
    check("rearm_busy", int'(busy), 1);
`ifdef FIR_CAP_MINMAX_EN
    check("rearm_min", int'(cap_min), 0);
    check("rearm_max", int'(cap_max), 0);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_capture_buf.md
Name: fir_capture_buf

Overview:
Capture buffer that sits downstream of the combined LP/HP/BP/MA FIR filter and consumes its outputs.
- On arm, selects one filter channel and waits for a trigger (immediate or signed threshold rising crossing).
- Then records DEPTH consecutive valid samples into on-chip memory.
- Exposes the samples through a one-at-a-time read port for readback and on-chip checking.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- DEPTH, 32, samples captured per arm; power of two.
- ADDR_W, 5, log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- lp_in  in  DATA_W  signed low-pass filter output.
- hp_in  in  DATA_W  signed high-pass filter output.
- bp_in  in  DATA_W  signed band-pass filter output.
- ma_in  in  DATA_W  signed moving-average filter output.
- in_valid  in  1  all four channel inputs carry a new sample this cycle.
- ch_sel  in  2  channel select: 0=LP, 1=HP, 2=BP, 3=MA; latched on arm.
- trig_mode  in  1  0=immediate, 1=rising threshold crossing; latched on arm.
- threshold  in  DATA_W  signed trigger level; latched on arm.
- arm  in  1  single-cycle start request.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE (buffer full, readable).
- rd_en  in  1  read request, one sample per asserted cycle.
- rd_data  out  DATA_W  signed read sample.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- rd_last  out  1  high with rd_valid on sample DEPTH-1.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; busy, done, rd_valid, rd_last=0; rd_data=0; write/read pointers=0; prev-sample flag cleared. Memory contents are not reset. Reset overrides every other input, including mid-capture and mid-readout.
- States are IDLE, ARMED, CAPTURE, DONE.
- IDLE: arm=1 latches ch_sel, trig_mode and threshold, clears both pointers, goes to ARMED. rd_en is ignored.
- ARMED: the selected sample s is examined only when in_valid=1.
  - trig_mode=0: the first valid s is written to addr 0; go to CAPTURE with wr_ptr=1.
  - trig_mode=1: trigger when a previous valid sample p exists, p < threshold and s >= threshold (signed compare). The triggering s is written to addr 0; go to CAPTURE.
  - Otherwise p <= s and set the prev flag. The first valid sample after arm never triggers in mode 1.
  - arm while ARMED re-latches the configuration and clears the prev flag.
- CAPTURE: each in_valid writes s to addr wr_ptr and increments wr_ptr. The write of addr DEPTH-1 moves the state to DONE on the same edge. Cycles with in_valid=0 hold. arm is ignored.
- DONE: rd_en=1 reads addr rd_ptr.
  - Read latency is 1 cycle: rd_valid and rd_data appear the next cycle, and rd_ptr increments.
  - rd_valid=0 in any cycle following rd_en=0. rd_data holds its last value.
  - The read of addr DEPTH-1 raises rd_last with its rd_valid, and the state returns to IDLE on that same rd_en edge. rd_en issued after that point is ignored.
  - arm and rd_en in the same DONE cycle: arm wins. No read is issued, and the block enters ARMED as from IDLE.
- busy and done are registered, and reflect the state after the edge.
- Pointers wrap modulo DEPTH. Because the state leaves CAPTURE/DONE at DEPTH-1, no wrap occurs in normal operation.
- Storage: synchronous-write, synchronous-read RAM, DEPTH x DATA_W.

Optional Feature:
- FIR_CAP_MINMAX_EN defined:
  - Adds outputs cap_min and cap_max (each DATA_W, signed).
  - Both are cleared to 0 on reset and on arm.
  - On the sample-0 write, both are set to s. Each subsequent capture write updates cap_min = min(cap_min, s) and cap_max = max(cap_max, s).
  - Both are stable while done=1 and held until the next arm.
- FIR_CAP_MINMAX_EN undefined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset mid-capture: arm with trig_mode=0, feed 10 valid samples, pull rst_n=0 for 1 cycle -> busy=0, done=0, rd_valid=0. Re-arm then captures from addr 0.
- Immediate capture, LP channel: ch_sel=0, trig_mode=0, lp_in ramps 1..40 with in_valid=1 every cycle -> done rises after 32 samples. 32 rd_en cycles return 1..32, and rd_last is high only with value 32.
- Crossing trigger, HP channel: threshold=0, hp_in alternates +50/-50 starting with +50 -> first sample ignored, trigger on the first -50->+50 transition. Readback gives +50,-50,+50,... (32 samples).
- Gapped valid, MA channel: in_valid toggles every other cycle with ma_in=50,0,-50,0 repeating -> only valid samples are stored. Readback is 50,0,-50,0 x8. busy stays high for about 64 cycles.
- Arm/read collision: in DONE, assert arm and rd_en together -> no rd_valid next cycle, busy=1, done=0.
- With FIR_CAP_MINMAX_EN, BP channel: bp_in pattern 50,0,-50,0 -> cap_min=-50, cap_max=50 at done. Arm clears both to 0.
